// File: rtl/vector_writeback_unit_pkg.sv
// Shared types for the vector writeback stage: FSM state encoding and the
// default-geometry vector register type.
package wb_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_VECTOR_SIZE   = 6;
    localparam int unsigned DEF_ADDRESS_WIDTH = 4;
    localparam int unsigned DEF_COUNT_WIDTH   = 3;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } wb_state_t;

    typedef logic [DEF_VECTOR_SIZE-1:0][DEF_DATA_WIDTH-1:0] vector_t;

endpackage

// File: rtl/vector_writeback_unit_load_assembler.sv
// Load assembler: gathers streamed memory elements (index 0 first) into a
// vector buffer and flags the element that completes the load.
module load_assembler
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned VECTOR_SIZE = DEF_VECTOR_SIZE,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  collect,
    input  logic                                  is_vector,
    input  logic                                  elem_valid,
    input  logic [DATA_WIDTH-1:0]                 elem_data,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] buffer,
    output logic                                  done
);

    localparam logic [COUNT_WIDTH-1:0] LAST_INDEX = COUNT_WIDTH'(VECTOR_SIZE - 1);

    logic [COUNT_WIDTH-1:0] count;

    // Store each valid element at the current index; a new load wipes stale data.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count  <= '0;
            buffer <= '0;
        end else if (collect && elem_valid) begin
            for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
                if (count == COUNT_WIDTH'(i)) begin
                    buffer[i] <= elem_data;
                end
            end
            count <= count + 1'b1;
        end
    end

    // Completion: first element of a scalar load, last index of a vector load.
    always_comb begin
        done = collect && elem_valid && (!is_vector || (count == LAST_INDEX));
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Writeback stage: merges ALU results and assembled load data onto the single
// register-file write port, with a one-cycle starvation bound for loads.
module vector_writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned VECTOR_SIZE   = DEF_VECTOR_SIZE,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   aluValid,
    input  logic                                   aluIsVector,
    input  logic [ADDRESS_WIDTH-1:0]               aluAddress,
    input  logic [DATA_WIDTH-1:0]                  aluScalarData,
    input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] aluVectorData,
    output logic                                   aluReady,
    input  logic                                   loadStart,
    input  logic                                   loadIsVector,
    input  logic [ADDRESS_WIDTH-1:0]               loadAddress,
    output logic                                   loadReady,
    input  logic                                   memElemValid,
    input  logic [DATA_WIDTH-1:0]                  memElemData,
    output logic                                   writeEnableScalar,
    output logic                                   writeEnableVector,
    output logic [ADDRESS_WIDTH-1:0]               writeAddress,
    output logic [DATA_WIDTH-1:0]                  writeScalarData,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] writeVectorData,
    output logic                                   busy
);

    wb_state_t                              state;
    wb_state_t                              state_next;
    logic                                   starve;
    logic                                   load_is_vector;
    logic [ADDRESS_WIDTH-1:0]               load_address;
    logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] buffer;
    logic                                   load_done;
    logic                                   load_accept;
    logic                                   alu_fire;
    logic                                   grant;

    load_assembler #(
        .DATA_WIDTH  (DATA_WIDTH),
        .VECTOR_SIZE (VECTOR_SIZE),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (load_accept),
        .collect    (state == COLLECT),
        .is_vector  (load_is_vector),
        .elem_valid (memElemValid),
        .elem_data  (memElemData),
        .buffer     (buffer),
        .done       (load_done)
    );

    // Next state, load grant and handshake signals derived from registered state.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        load_accept = 1'b0;
        aluReady    = !((state == COMMIT) && starve);
        loadReady   = (state == IDLE);
        busy        = (state != IDLE);
        alu_fire    = aluValid && aluReady;
        case (state)
            IDLE: begin
                if (loadStart) begin
                    load_accept = 1'b1;
                    state_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (load_done) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (!aluValid || starve) begin
                    grant      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, load descriptor latch and starvation flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            starve         <= 1'b0;
            load_is_vector <= 1'b0;
            load_address   <= '0;
        end else begin
            state <= state_next;
            if (load_accept) begin
                load_is_vector <= loadIsVector;
                load_address   <= loadAddress;
            end
            if (grant) begin
                starve <= 1'b0;
            end else if ((state == COMMIT) && aluValid) begin
                starve <= 1'b1;
            end
        end
    end

    // Registered write port; alu_fire and grant are mutually exclusive by construction.
    always_ff @(posedge clock) begin
        if (reset) begin
            writeEnableScalar <= 1'b0;
            writeEnableVector <= 1'b0;
            writeAddress      <= '0;
            writeScalarData   <= '0;
            writeVectorData   <= '0;
        end else begin
            writeEnableScalar <= 1'b0;
            writeEnableVector <= 1'b0;
            if (alu_fire) begin
                writeEnableScalar <= !aluIsVector;
                writeEnableVector <= aluIsVector;
                writeAddress      <= aluAddress;
                writeScalarData   <= aluIsVector ? '0 : aluScalarData;
                writeVectorData   <= aluIsVector ? aluVectorData : '0;
            end else if (grant) begin
                writeEnableScalar <= !load_is_vector;
                writeEnableVector <= load_is_vector;
                writeAddress      <= load_address;
                writeScalarData   <= load_is_vector ? '0 : buffer[0];
                writeVectorData   <= load_is_vector ? buffer : '0;
            end
        end
    end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Scoreboard bench for vector_writeback_unit: a transaction-level model predicts
// each register-file write; a monitor pops and compares what the DUT emits.
module tb_vector_writeback_unit;
    import wb_pkg::*;

    typedef struct packed {
        logic       is_vec;
        logic [3:0] addr;
        logic [7:0] sdata;
        vector_t    vdata;
    } wr_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       aluValid = 1'b0, aluIsVector = 1'b0, aluReady;
    logic [3:0] aluAddress = '0;
    logic [7:0] aluScalarData = '0;
    vector_t    aluVectorData = '0;
    logic       loadStart = 1'b0, loadIsVector = 1'b0, loadReady;
    logic [3:0] loadAddress = '0;
    logic       memElemValid = 1'b0;
    logic [7:0] memElemData = '0;
    logic       writeEnableScalar, writeEnableVector, busy;
    logic [3:0] writeAddress;
    logic [7:0] writeScalarData;
    vector_t    writeVectorData;

    vector_writeback_unit #(
        .DATA_WIDTH    (8),
        .VECTOR_SIZE   (6),
        .ADDRESS_WIDTH (4),
        .COUNT_WIDTH   (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .aluValid          (aluValid),
        .aluIsVector       (aluIsVector),
        .aluAddress        (aluAddress),
        .aluScalarData     (aluScalarData),
        .aluVectorData     (aluVectorData),
        .aluReady          (aluReady),
        .loadStart         (loadStart),
        .loadIsVector      (loadIsVector),
        .loadAddress       (loadAddress),
        .loadReady         (loadReady),
        .memElemValid      (memElemValid),
        .memElemData       (memElemData),
        .writeEnableScalar (writeEnableScalar),
        .writeEnableVector (writeEnableVector),
        .writeAddress      (writeAddress),
        .writeScalarData   (writeScalarData),
        .writeVectorData   (writeVectorData),
        .busy              (busy)
    );

    always #5 clock = ~clock;

    int  compared   = 0;
    int  mismatched = 0;
    bit  mon_on     = 1'b0;
    bit  model_ok   = 1'b0;

    // Reference model: a load is "none" (0), "collecting" (1) or "waiting for the port" (2).
    wr_t        exp_q[$];
    wr_t        hold;
    int         phase = 0;
    bit         lost_once = 1'b0;
    bit         l_vec = 1'b0;
    logic [3:0] l_addr = '0;
    logic [7:0] elems[$];

    function automatic void check(string name, logic [255:0] act, logic [255:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // One clock of stimulus; the model predicts what the next rising edge does.
    task automatic step(input bit rst, input bit av, input bit aiv, input logic [3:0] aa,
                        input logic [7:0] asd, input vector_t avd, input bit ls, input bit liv,
                        input logic [3:0] la, input bit mv, input logic [7:0] md);
        bit  exp_ready, alu_acc, load_win;
        wr_t w;
        @(negedge clock);
        if (model_ok) begin
            check("aluReady", 256'(aluReady), 256'(!(phase == 2 && lost_once)));
            check("loadReady", 256'(loadReady), 256'(phase == 0));
            check("busy", 256'(busy), 256'(phase != 0));
        end
        reset = rst; aluValid = av; aluIsVector = aiv; aluAddress = aa; aluScalarData = asd;
        aluVectorData = avd; loadStart = ls; loadIsVector = liv; loadAddress = la;
        memElemValid = mv; memElemData = md;
        mon_on = 1'b1;
        if (rst) begin
            phase = 0; lost_once = 1'b0; elems.delete(); hold = '0; model_ok = 1'b1;
            return;
        end
        exp_ready = !(phase == 2 && lost_once);
        alu_acc   = av && exp_ready;
        load_win  = (phase == 2) && (!av || lost_once);
        if (alu_acc) begin
            w.is_vec = aiv; w.addr = aa;
            w.sdata = aiv ? 8'h00 : asd;
            w.vdata = aiv ? avd : '0;
            exp_q.push_back(w); hold = w;
        end else if (load_win) begin
            w.is_vec = l_vec; w.addr = l_addr; w.vdata = '0;
            w.sdata = l_vec ? 8'h00 : elems[0];
            if (l_vec) for (int i = 0; i < 6; i++) w.vdata[i] = elems[i];
            exp_q.push_back(w); hold = w;
        end
        case (phase)
            0: if (ls) begin phase = 1; l_vec = liv; l_addr = la; elems.delete(); end
            1: if (mv) begin
                elems.push_back(md);
                if (elems.size() == (l_vec ? 6 : 1)) phase = 2;
            end
            default: if (load_win) begin phase = 0; lost_once = 1'b0; end
                     else lost_once = 1'b1;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic elem(input logic [7:0] d);
        step(0, 0, 0, 0, 0, '0, 0, 0, 0, 1, d);
    endtask

    // Monitor: every cycle after the edge, pop an expected write or confirm idle port holds.
    always begin
        wr_t e;
        @(posedge clock);
        #1;
        if (mon_on) begin
            if (writeEnableScalar || writeEnableVector || exp_q.size() > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {writeEnableVector, writeEnableScalar}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("we_scalar", 256'(writeEnableScalar), 256'(!e.is_vec));
                    check("we_vector", 256'(writeEnableVector), 256'(e.is_vec));
                    check("wr_addr", 256'(writeAddress), 256'(e.addr));
                    check("wr_sdata", 256'(writeScalarData), 256'(e.sdata));
                    check("wr_vdata", 256'(writeVectorData), 256'(e.vdata));
                end
            end else begin
                check("hold_addr", 256'(writeAddress), 256'(hold.addr));
                check("hold_sdata", 256'(writeScalarData), 256'(hold.sdata));
                check("hold_vdata", 256'(writeVectorData), 256'(hold.vdata));
            end
        end
    end

    initial begin
        vector_t rv;
        step(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        idle(2);

        // Scalar ALU write
        step(0, 1, 0, 4'd3, 8'h5A, '0, 0, 0, 0, 0, 0);
        idle(2);

        // Vector load with a gap in the element stream
        step(0, 0, 0, 0, 0, '0, 1, 1, 4'd7, 0, 0);
        elem(8'd1); elem(8'd2); elem(8'd3);
        idle(1);
        elem(8'd4); elem(8'd5); elem(8'd6);
        idle(3);

        // Contention: ALU valid every cycle while the load waits
        step(0, 0, 0, 0, 0, '0, 1, 0, 4'd5, 0, 0);
        elem(8'hAA);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 4'(i + 8), 8'(i + 8'h10), '0, 0, 0, 0, 0, 0);
        idle(2);

        // Scalar load
        step(0, 0, 0, 0, 0, '0, 1, 0, 4'd2, 0, 0);
        elem(8'hC3);
        idle(3);

        // Reset part-way through a vector load, then a clean load
        step(0, 0, 0, 0, 0, '0, 1, 1, 4'd9, 0, 0);
        elem(8'hE1); elem(8'hE2); elem(8'hE3);
        step(1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0);
        idle(10);
        step(0, 0, 0, 0, 0, '0, 1, 1, 4'd4, 0, 0);
        for (int i = 0; i < 6; i++) elem(8'(8'h30 + i));
        idle(3);

        // ALU vector write while a load is collecting
        step(0, 0, 0, 0, 0, '0, 1, 1, 4'd1, 0, 0);
        elem(8'h41); elem(8'h42);
        for (int i = 0; i < 6; i++) rv[i] = 8'(8'h90 + i);
        step(0, 1, 1, 4'd6, 8'hFF, rv, 1, 0, 0, 1, 8'h43);
        elem(8'h44); elem(8'h45); elem(8'h46);
        idle(3);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 6; i++) rv[i] = 8'($urandom);
            step($urandom_range(0, 199) == 0,
                 (phase == 2) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 4),
                 1'($urandom), 4'($urandom), 8'($urandom), rv,
                 $urandom_range(0, 9) < 3, 1'($urandom), 4'($urandom),
                 $urandom_range(0, 9) < 6, 8'($urandom));
        end
        idle(12);
        @(negedge clock);
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
